// File: rtl/aexm_mdu_pkg.sv
// Shared op encodings, FSM state encoding and width default for the aexm multiply/divide unit.
package aexm_mdu_pkg;

  localparam int unsigned MDU_DW = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHU  = 3'd2;
  localparam logic [2:0] MDU_MULHSU = 3'd3;
  localparam logic [2:0] MDU_IDIV   = 3'd4;
  localparam logic [2:0] MDU_IDIVU  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/aexm_mdu_if.sv
// Execute-stage <-> MDU request/result bundle; master is the execute stage, slave is the MDU.
interface aexm_mdu_if #(
  parameter int unsigned DW = aexm_mdu_pkg::MDU_DW
);
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          dz;

  modport master (output start, op, opa, opb, input busy, done, result, dz);
  modport slave  (input start, op, opa, opb, output busy, done, result, dz);
endinterface

// File: rtl/aexm_mdu_div.sv
// Iterative restoring divider on magnitudes, one quotient bit per cycle; sign fix-up is left to the caller.
// done_c is high during the final iteration cycle, so quoMag is complete after that edge.
module aexm_mdu_div
  import aexm_mdu_pkg::*;
#(
  parameter int unsigned DW = MDU_DW
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          start,
  input  logic          sgn,
  input  logic [DW-1:0] dvd,
  input  logic [DW-1:0] dvs,
  output logic          busy,
  output logic          done_c,
  output logic [DW-1:0] quoMag,
  output logic          quoNeg
);
  localparam int unsigned CW = $clog2(DW + 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] dvsR;
  logic          dvdNeg;
  logic          dvsNeg;
  logic [DW-1:0] dvdMag;
  logic [DW-1:0] dvsMag;
  logic [DW:0]   remShift;
  logic [DW:0]   diff;

  assign dvdNeg   = sgn & dvd[DW-1];
  assign dvsNeg   = sgn & dvs[DW-1];
  assign dvdMag   = dvdNeg ? DW'(-dvd) : dvd;
  assign dvsMag   = dvsNeg ? DW'(-dvs) : dvs;
  assign remShift = {rem, quoMag[DW-1]};
  assign diff     = remShift - {1'b0, dvsR};
  assign done_c   = busy & (cnt == CW'(1));

  // quoMag doubles as the dividend shift register while iterating
  always_ff @(posedge gclk) begin
    if (grst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      dvsR   <= '0;
      quoMag <= '0;
      quoNeg <= 1'b0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= CW'(DW);
      rem    <= '0;
      dvsR   <= dvsMag;
      quoMag <= dvdMag;
      quoNeg <= dvdNeg ^ dvsNeg;
    end else if (busy) begin
      cnt    <= cnt - CW'(1);
      rem    <= diff[DW] ? remShift[DW-1:0] : diff[DW-1:0];
      quoMag <= {quoMag[DW-2:0], ~diff[DW]};
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/aexm_mdu.sv
// aexm execute-stage multiply/divide unit: MUL_STAGES-deep multiplier pipeline plus optional divider.
// Define AEXM_MDU_DIV_EN to build the divider; otherwise IDIV/IDIVU complete like reserved ops.
module aexm_mdu
  import aexm_mdu_pkg::*;
#(
  parameter int unsigned DW         = MDU_DW,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic       gclk,
  input  logic       grst,
  aexm_mdu_if.slave  bus
);
  localparam int unsigned PW = 2 * DW;

  logic [1:0]    state;
  logic [1:0]    stateNxt;
  logic [2:0]    opR;
  logic [DW-1:0] opaR;
  logic [DW-1:0] opbR;
  logic [MUL_STAGES-1:0] vld;
  logic [PW-1:0] pp [MUL_STAGES];
  logic          busyR;
  logic          doneR;
  logic          dzR;
  logic [DW-1:0] resultR;
  logic [DW-1:0] resultNxt;
  logic          dzNxt;
  logic          accept;
  logic          sA;
  logic          sB;
  logic [PW-1:0] extA;
  logic [PW-1:0] extB;
  logic [PW-1:0] prod;

  assign accept = (state == ST_IDLE) & bus.start;

  // signedness is taken from the registered op so the product lines up with opaR/opbR
  assign sA   = (opR == MDU_MULH) | (opR == MDU_MULHSU);
  assign sB   = (opR == MDU_MULH);
  assign extA = {{DW{sA & opaR[DW-1]}}, opaR};
  assign extB = {{DW{sB & opbR[DW-1]}}, opbR};
  assign prod = extA * extB;

`ifdef AEXM_MDU_DIV_EN
  logic          isDivIn;
  logic          divStart;
  logic          divBusy;
  logic          divDone_c;
  logic [DW-1:0] quoMag;
  logic          quoNeg;
  logic          dzPend;

  assign isDivIn  = (bus.op == MDU_IDIV) | (bus.op == MDU_IDIVU);
  assign divStart = accept & isDivIn & (bus.opa != '0) & ~divBusy;

  aexm_mdu_div #(.DW(DW)) u_div (
    .gclk   (gclk),
    .grst   (grst),
    .start  (divStart),
    .sgn    (bus.op == MDU_IDIV),
    .dvd    (bus.opb),
    .dvs    (bus.opa),
    .busy   (divBusy),
    .done_c (divDone_c),
    .quoMag (quoMag),
    .quoNeg (quoNeg)
  );

  always_ff @(posedge gclk) begin
    if (grst)        dzPend <= 1'b0;
    else if (accept) dzPend <= isDivIn & (bus.opa == '0);
  end
`endif

  // next state and the value FIN will commit
  always_comb begin
    stateNxt  = state;
    resultNxt = '0;
    dzNxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          stateNxt = ST_FIN;
          if (!bus.op[2]) stateNxt = ST_MUL;
`ifdef AEXM_MDU_DIV_EN
          else if (isDivIn && bus.opa != '0) stateNxt = ST_DIV;
`endif
        end
      end
      ST_MUL:  if (vld[MUL_STAGES-1]) stateNxt = ST_FIN;
`ifdef AEXM_MDU_DIV_EN
      ST_DIV:  if (divDone_c) stateNxt = ST_FIN;
`endif
      ST_FIN:  stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase

    case (opR)
      MDU_MUL:                         resultNxt = pp[MUL_STAGES-1][DW-1:0];
      MDU_MULH, MDU_MULHU, MDU_MULHSU: resultNxt = pp[MUL_STAGES-1][PW-1:DW];
`ifdef AEXM_MDU_DIV_EN
      MDU_IDIV, MDU_IDIVU: begin
        if (dzPend) dzNxt = 1'b1;
        else        resultNxt = quoNeg ? DW'(-quoMag) : quoMag;
      end
`endif
      default: ;
    endcase
  end

  // vld[i] marks data that lands in pp[i] on the next edge, so the last bit doubles as the FIN trigger
  always_ff @(posedge gclk) begin
    if (grst) begin
      state   <= ST_IDLE;
      opR     <= '0;
      opaR    <= '0;
      opbR    <= '0;
      vld     <= '0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      dzR     <= 1'b0;
      resultR <= '0;
      for (int i = 0; i < int'(MUL_STAGES); i++) pp[i] <= '0;
    end else begin
      state <= stateNxt;
      busyR <= (stateNxt != ST_IDLE);
      doneR <= (state == ST_FIN);
      if (state == ST_FIN) begin
        resultR <= resultNxt;
        dzR     <= dzNxt;
      end
      if (accept) begin
        opR  <= bus.op;
        opaR <= bus.opa;
        opbR <= bus.opb;
      end
      vld[0] <= accept & ~bus.op[2];
      pp[0]  <= prod;
      for (int i = 1; i < int'(MUL_STAGES); i++) begin
        vld[i] <= vld[i-1];
        pp[i]  <= pp[i-1];
      end
    end
  end

  assign bus.busy   = busyR;
  assign bus.done   = doneR;
  assign bus.result = resultR;
  assign bus.dz     = dzR;

endmodule

// File: tb/tb_aexm_mdu.sv
// Directed self-checking bench for aexm_mdu (DW=32, MUL_STAGES=2); expectations follow AEXM_MDU_DIV_EN.
module tb_aexm_mdu;
  import aexm_mdu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned MS = 2;
`ifdef AEXM_MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int DIV_LAT = DIV_ON ? DW + 1 : 1;
  localparam int MUL_LAT = MS + 1;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  always #5 gclk = ~gclk;

  aexm_mdu_if #(.DW(DW)) bus ();

  aexm_mdu #(.DW(DW), .MUL_STAGES(MS)) dut (
    .gclk (gclk),
    .grst (grst),
    .bus  (bus)
  );

  int nCmp = 0;
  int nBad = 0;

  // launch one op at the next negedge; lat = edges after accept until done, -1 on timeout
  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int lat);
    @(negedge gclk);
    bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
    @(posedge gclk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge gclk); #1;
      if (bus.done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    grst = 1'b1;
    repeat (3) @(posedge gclk);
    #1;
    nCmp++; if (bus.busy !== 1'b0) begin nBad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    nCmp++; if (bus.done !== 1'b0) begin nBad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    nCmp++; if (bus.result !== 32'h0) begin nBad++; $display("FAIL rst_result: got %h want 0", bus.result); end
    nCmp++; if (bus.dz !== 1'b0) begin nBad++; $display("FAIL rst_dz: got %b want 0", bus.dz); end
    @(negedge gclk);
    grst = 1'b0;
  endtask

  task automatic test_mul();
    int lat;
    issue(MDU_MUL, 32'h0001_0000, 32'h0003_0000, lat);
    nCmp++; if (lat !== MUL_LAT) begin nBad++; $display("FAIL mul_lat: got %0d want %0d", lat, MUL_LAT); end
    nCmp++; if (bus.result !== 32'h0) begin nBad++; $display("FAIL mul_lo: got %h want 00000000", bus.result); end
    @(posedge gclk); #1;
    nCmp++; if (bus.done !== 1'b0) begin nBad++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
    issue(MDU_MULHU, 32'h0001_0000, 32'h0003_0000, lat);
    nCmp++; if (lat !== MUL_LAT) begin nBad++; $display("FAIL mulhu_lat: got %0d want %0d", lat, MUL_LAT); end
    nCmp++; if (bus.result !== 32'h3) begin nBad++; $display("FAIL mulhu_small: got %h want 00000003", bus.result); end
  endtask

  task automatic test_mul_high();
    int lat;
    issue(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    nCmp++; if (bus.result !== 32'h0) begin nBad++; $display("FAIL mulh: got %h want 00000000", bus.result); end
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    nCmp++; if (bus.result !== 32'hFFFF_FFFE) begin nBad++; $display("FAIL mulhu: got %h want fffffffe", bus.result); end
    issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    nCmp++; if (bus.result !== 32'hFFFF_FFFF) begin nBad++; $display("FAIL mulhsu: got %h want ffffffff", bus.result); end
    issue(3'd6, 32'h1234_5678, 32'h9, lat);
    nCmp++; if (lat !== 1) begin nBad++; $display("FAIL rsvd_lat: got %0d want 1", lat); end
    nCmp++; if (bus.result !== 32'h0) begin nBad++; $display("FAIL rsvd_result: got %h want 0", bus.result); end
  endtask

  task automatic test_div();
    int lat;
    logic [DW-1:0] exp1, exp2;
    exp1 = DIV_ON ? 32'hFFFF_FFFD : 32'h0;
    exp2 = DIV_ON ? 32'd14 : 32'h0;
    issue(MDU_IDIV, 32'd2, 32'hFFFF_FFF9, lat);
    nCmp++; if (lat !== DIV_LAT) begin nBad++; $display("FAIL idiv_lat: got %0d want %0d", lat, DIV_LAT); end
    nCmp++; if (bus.result !== exp1) begin nBad++; $display("FAIL idiv_neg: got %h want %h", bus.result, exp1); end
    issue(MDU_IDIVU, 32'd7, 32'd100, lat);
    nCmp++; if (bus.result !== exp2) begin nBad++; $display("FAIL idivu: got %h want %h", bus.result, exp2); end
    nCmp++; if (bus.dz !== 1'b0) begin nBad++; $display("FAIL idivu_dz: got %b want 0", bus.dz); end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(MDU_IDIVU, 32'd0, 32'd5, lat);
    nCmp++; if (lat !== 1) begin nBad++; $display("FAIL dz_lat: got %0d want 1", lat); end
    nCmp++; if (bus.result !== 32'h0) begin nBad++; $display("FAIL dz_result: got %h want 0", bus.result); end
    nCmp++; if (bus.dz !== DIV_ON) begin nBad++; $display("FAIL dz_flag: got %b want %b", bus.dz, DIV_ON); end
    issue(MDU_MUL, 32'd6, 32'd7, lat);
    nCmp++; if (bus.dz !== 1'b0) begin nBad++; $display("FAIL dz_clear: got %b want 0", bus.dz); end
    nCmp++; if (bus.result !== 32'd42) begin nBad++; $display("FAIL dz_mul: got %h want 0000002a", bus.result); end
  endtask

  task automatic test_ovf_busy_start();
    int nd, firstDone;
    logic [DW-1:0] expRes;
    expRes = DIV_ON ? 32'h8000_0000 : 32'h0;
    nd = 0; firstDone = -1;
    @(negedge gclk);
    bus.start = 1'b1; bus.op = MDU_IDIV; bus.opa = 32'hFFFF_FFFF; bus.opb = 32'h8000_0000;
    @(posedge gclk); #1;
    nCmp++; if (bus.busy !== 1'b1) begin nBad++; $display("FAIL ovf_busy: got %b want 1", bus.busy); end
    // keep hammering start with a different op while busy
    for (int j = 1; j <= DIV_LAT + 8; j++) begin
      bus.start = (j < DIV_LAT); bus.op = MDU_MUL; bus.opa = 32'd3; bus.opb = 32'd5;
      @(posedge gclk); #1;
      if (bus.done) begin nd++; if (firstDone < 0) firstDone = j; end
    end
    bus.start = 1'b0;
    nCmp++; if (nd !== 1) begin nBad++; $display("FAIL ovf_done_count: got %0d want 1", nd); end
    nCmp++; if (firstDone !== DIV_LAT) begin nBad++; $display("FAIL ovf_lat: got %0d want %0d", firstDone, DIV_LAT); end
    nCmp++; if (bus.result !== expRes) begin nBad++; $display("FAIL ovf_result: got %h want %h", bus.result, expRes); end
    nCmp++; if (bus.dz !== 1'b0) begin nBad++; $display("FAIL ovf_dz: got %b want 0", bus.dz); end
  endtask

  task automatic test_reset_mid_op();
    int lat, nd, rstAt;
    logic [2:0] o;
    logic [DW-1:0] expRes;
    rstAt  = DIV_ON ? 10 : 1;
    o      = DIV_ON ? MDU_IDIVU : MDU_MUL;
    expRes = DIV_ON ? 32'd14 : 32'h0;
    nd = 0;
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    nCmp++; if (bus.result !== 32'hFFFF_FFFE) begin nBad++; $display("FAIL pre_rst_result: got %h want fffffffe", bus.result); end
    @(negedge gclk);
    bus.start = 1'b1; bus.op = o; bus.opa = 32'd7; bus.opb = 32'd100;
    @(posedge gclk); #1;
    bus.start = 1'b0;
    for (int j = 1; j < rstAt; j++) begin
      @(posedge gclk); #1;
      if (bus.done) nd++;
    end
    grst = 1'b1;
    @(posedge gclk); #1;
    grst = 1'b0;
    nCmp++; if (bus.busy !== 1'b0) begin nBad++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    nCmp++; if (bus.result !== 32'h0) begin nBad++; $display("FAIL mid_rst_result: got %h want 0", bus.result); end
    nCmp++; if (bus.done !== 1'b0) begin nBad++; $display("FAIL mid_rst_done: got %b want 0", bus.done); end
    for (int j = 0; j < 40; j++) begin
      @(posedge gclk); #1;
      if (bus.done) nd++;
    end
    nCmp++; if (nd !== 0) begin nBad++; $display("FAIL mid_rst_no_done: got %0d dones want 0", nd); end
    issue(MDU_IDIVU, 32'd7, 32'd100, lat);
    nCmp++; if (lat !== DIV_LAT) begin nBad++; $display("FAIL post_rst_lat: got %0d want %0d", lat, DIV_LAT); end
    nCmp++; if (bus.result !== expRes) begin nBad++; $display("FAIL post_rst_result: got %h want %h", bus.result, expRes); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.opa   = '0;
    bus.opb   = '0;
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_div_zero();
    test_ovf_busy_start();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
